hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage MIPS core. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and generates their stall and flush controls and the forwarding selects. It also sequences multi-cycle data-memory accesses through a wait FSM with a timeout, and keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard, forwarding and memory-wait controller
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             JumpD,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_wait_cnt, w_wait_cnt_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_memstall, w_lwstall, w_brstall;

  // register 0 is hard-wired zero, so a match on it is never a dependency
  function automatic logic f_hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // timeout fires on the MEM_TIMEOUT-th WAIT cycle; a same-cycle ready still wins
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_memstall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MemReqM && !MemReadyM) begin
          w_memstall     = 1'b1;
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = 16'd0;
        end
      end
      S_WAIT: begin
        w_wait_cnt_nxt = r_wait_cnt + 16'd1;
        if (MemReadyM) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_memstall = 1'b1;
          if (r_wait_cnt == TO_LAST) w_state_nxt = S_ERR;
        end
      end
      S_ERR:   w_memstall = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_lwstall = MemtoRegE && RegWriteE &&
                     (f_hit(RsD, WriteRegE) || f_hit(RtD, WriteRegE));
  assign w_brstall = BranchD &&
                     ((RegWriteE && (f_hit(RsD, WriteRegE) || f_hit(RtD, WriteRegE))) ||
                      (MemtoRegM && (f_hit(RsD, WriteRegM) || f_hit(RtD, WriteRegM))));

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (!rst_n) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      if (RegWriteM && f_hit(RsE, WriteRegM))      ForwardAE = 2'b10;
      else if (RegWriteW && f_hit(RsE, WriteRegW)) ForwardAE = 2'b01;
      if (RegWriteM && f_hit(RtE, WriteRegM))      ForwardBE = 2'b10;
      else if (RegWriteW && f_hit(RtE, WriteRegW)) ForwardBE = 2'b01;
      ForwardAD = RegWriteM && f_hit(RsD, WriteRegM);
      ForwardBD = RegWriteM && f_hit(RtD, WriteRegM);
      if (w_memstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (w_lwstall || w_brstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (PCSrcD || JumpD) begin
        FlushD = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (StallF && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign MemErr      = (r_state == S_ERR);
  assign StallCycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic        BranchD, PCSrcD, JumpD, MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        ForwardAD, ForwardBD, MemErr;
  logic [15:0] StallCycles;
  logic [6:0]  ctl;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .JumpD(JumpD),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MemErr(MemErr), .StallCycles(StallCycles)
  );

  always #5 clk = ~clk;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; PCSrcD = 0; JumpD = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  // inputs change just after the falling edge; checks land 1ns later
  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ctl", 32'(ctl), 32'(7'b0000111));
    chk("rst_memerr", 32'(MemErr), 32'd0);
    chk("rst_cnt", 32'(StallCycles), 32'd0);
    nx(); rst_n = 1'b1; #1;
    chk("idle_ctl", 32'(ctl), 32'(7'b0000000));

    // forwarding
    nx(); RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5; RsE = 5; #1;
    chk("fwd_ae_mem", 32'(ForwardAE), 32'd2);
    chk("fwd_be_none", 32'(ForwardBE), 32'd0);
    RtE = 5; #1;
    chk("fwd_be_mem", 32'(ForwardBE), 32'd2);
    RegWriteM = 0; #1;
    chk("fwd_ae_wb", 32'(ForwardAE), 32'd1);
    RegWriteM = 1; WriteRegM = 0; WriteRegW = 0; RsE = 0; RtE = 0; #1;
    chk("fwd_ae_r0", 32'(ForwardAE), 32'd0);
    WriteRegM = 9; RsD = 9; #1;
    chk("fwd_ad", 32'(ForwardAD), 32'd1);
    chk("fwd_bd", 32'(ForwardBD), 32'd0);
    chk("fwd_nostall", 32'(ctl), 32'(7'b0000000));

    // load-use
    nx(); clear_inputs(); MemtoRegE = 1; RegWriteE = 1; WriteRegE = 3; RtD = 3; #1;
    chk("lw_ctl", 32'(ctl), 32'(7'b1100010));
    nx(); clear_inputs(); #1;
    chk("lw_done", 32'(ctl), 32'(7'b0000000));
    chk("lw_cnt", 32'(StallCycles), 32'd1);

    // branch hazard, taken branch held during the stall
    nx(); BranchD = 1; PCSrcD = 1; RsD = 7; RegWriteE = 1; WriteRegE = 7; #1;
    chk("br_ctl", 32'(ctl), 32'(7'b1100010));
    nx(); RegWriteE = 0; WriteRegE = 0; #1;
    chk("br_taken", 32'(ctl), 32'(7'b0000100));
    chk("br_cnt", 32'(StallCycles), 32'd2);

    // branch on a load: two stall cycles
    nx(); clear_inputs(); BranchD = 1; RsD = 8; MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; #1;
    chk("brlw_c1", 32'(ctl), 32'(7'b1100010));
    nx(); MemtoRegE = 0; RegWriteE = 0; WriteRegE = 0;
    MemtoRegM = 1; RegWriteM = 1; WriteRegM = 8; #1;
    chk("brlw_c2", 32'(ctl), 32'(7'b1100010));
    nx(); clear_inputs(); #1;
    chk("brlw_done", 32'(ctl), 32'(7'b0000000));
    chk("brlw_cnt", 32'(StallCycles), 32'd4);

    // multi-cycle memory, ready on the 4th cycle
    nx(); MemReqM = 1; MemReadyM = 0; #1;
    chk("mem_c1", 32'(ctl), 32'(7'b1111001));
    nx(); #1;
    chk("mem_c2", 32'(ctl), 32'(7'b1111001));
    nx(); #1;
    chk("mem_c3", 32'(ctl), 32'(7'b1111001));
    nx(); MemReadyM = 1; #1;
    chk("mem_c4", 32'(ctl), 32'(7'b0000000));
    nx(); MemReqM = 0; MemReadyM = 0; #1;
    chk("mem_idle", 32'(ctl), 32'(7'b0000000));
    chk("mem_cnt", 32'(StallCycles), 32'd7);

    // zero-wait access
    nx(); MemReqM = 1; MemReadyM = 1; #1;
    chk("zw_ctl", 32'(ctl), 32'(7'b0000000));
    nx(); #1;
    chk("zw_cnt", 32'(StallCycles), 32'd7);

    // ready arriving on the timeout cycle wins
    nx(); MemReadyM = 0;
    for (int i = 0; i < 4; i++) nx();
    MemReadyM = 1; #1;
    chk("to_ready_ctl", 32'(ctl), 32'(7'b0000000));
    nx(); MemReqM = 0; MemReadyM = 0; #1;
    chk("to_ready_err", 32'(MemErr), 32'd0);
    chk("to_ready_idle", 32'(ctl), 32'(7'b0000000));
    chk("to_ready_cnt", 32'(StallCycles), 32'd11);

    // timeout: MemErr after 5 cycles, sticky
    nx(); MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 4; i++) nx();
    #1;
    chk("to_pre_err", 32'(MemErr), 32'd0);
    nx(); #1;
    chk("to_err", 32'(MemErr), 32'd1);
    chk("to_err_ctl", 32'(ctl), 32'(7'b1111001));
    chk("to_err_cnt", 32'(StallCycles), 32'd16);
    nx(); MemReqM = 0; MemReadyM = 1; #1;
    chk("err_sticky", 32'(MemErr), 32'd1);
    chk("err_stall", 32'(ctl), 32'(7'b1111001));

    // reset out of ERR
    nx(); MemReadyM = 0; rst_n = 1'b0; #1;
    chk("rst_err_ctl", 32'(ctl), 32'(7'b0000111));
    chk("rst_err_memerr", 32'(MemErr), 32'd0);
    chk("rst_err_cnt", 32'(StallCycles), 32'd0);
    nx(); rst_n = 1'b1; #1;
    chk("rel_err_ctl", 32'(ctl), 32'(7'b0000000));

    // reset mid-WAIT, then IDLE with no request means no stall
    nx(); MemReqM = 1;
    nx(); nx(); #1;
    chk("wait_pre_rst", 32'(ctl), 32'(7'b1111001));
    rst_n = 1'b0; #1;
    chk("rst_wait_ctl", 32'(ctl), 32'(7'b0000111));
    chk("rst_wait_cnt", 32'(StallCycles), 32'd0);
    nx(); MemReqM = 0; rst_n = 1'b1; #1;
    chk("rel_wait_ctl", 32'(ctl), 32'(7'b0000000));
    chk("rel_wait_err", 32'(MemErr), 32'd0);
    nx(); #1;
    chk("rel_wait_cnt", 32'(StallCycles), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
